// File: rtl/clint_multi_if.sv
// Register-bus bundle for the CLINT: one-cycle request, registered ack/err/rddata reply.
interface clint_multi_if;
  logic        i_wen;
  logic        i_ren;
  logic [31:0] i_addr;
  logic [31:0] i_wrdata;
  logic [31:0] o_rddata;
  logic        o_ack;
  logic        o_err;

  modport master (output i_wen, i_ren, i_addr, i_wrdata, input o_rddata, o_ack, o_err);
  modport slave  (input i_wen, i_ren, i_addr, i_wrdata, output o_rddata, o_ack, o_err);
endinterface

// File: rtl/clint_multi.sv
// Core-local interruptor: shared 64-bit mtime with prescaler, per-hart msip and mtimecmp,
// registered timer interrupts and a single-cycle-ack register bus.
module clint_multi_hart (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        wr_msip,
  input  logic        wr_cmp_lo,
  input  logic        wr_cmp_hi,
  input  logic [31:0] wrdata,
  input  logic [63:0] mtime,
  output logic        msip,
  output logic [63:0] mtimecmp,
  output logic        mtip
);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      msip     <= 1'b0;
      mtimecmp <= '1;
      mtip     <= 1'b0;
    end else begin
      if (wr_msip)   msip            <= wrdata[0];
      if (wr_cmp_lo) mtimecmp[31:0]  <= wrdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= wrdata;
      // Compare uses pre-edge values, so mtip lags mtime/mtimecmp by one cycle.
      mtip <= (mtime >= mtimecmp);
    end
  end
endmodule

module clint_multi #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int          N_HARTS   = 2,
  parameter int          TICK_DIV  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  clint_multi_if.slave       bus,
  output logic [N_HARTS-1:0] o_msip,
  output logic [N_HARTS-1:0] o_mtip
);
  localparam logic [3:0] NH = 4'(N_HARTS);
  localparam int         PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [31:0] off;
  logic        acc, aligned, valid, wr;
  logic [2:0]  msip_h, cmp_h;
  logic        cmp_hi;
  logic        hit_msip, hit_cmp, hit_lo, hit_hi;
  logic        wr_lo, wr_hi;

  // Addresses below BASE_ADDR wrap to huge offsets and fall outside every window.
  assign off      = bus.i_addr - BASE_ADDR;
  assign acc      = bus.i_wen | bus.i_ren;
  assign aligned  = (bus.i_addr[1:0] == 2'b00);
  assign msip_h   = off[4:2];
  assign cmp_h    = off[5:3];
  assign cmp_hi   = off[2];
  assign hit_msip = (off[31:5] == 27'd0) && ({1'b0, msip_h} < NH);
  assign hit_cmp  = (off[31:6] == 26'h100) && ({1'b0, cmp_h} < NH);
  assign hit_lo   = (off == 32'h0000_BFF8);
  assign hit_hi   = (off == 32'h0000_BFFC);
  assign valid    = aligned & (hit_msip | hit_cmp | hit_lo | hit_hi);
  assign wr       = bus.i_wen & valid;
  assign wr_lo    = wr & hit_lo;
  assign wr_hi    = wr & hit_hi;

  logic [PW-1:0] presc;
  logic          tick;
  logic [63:0]   mtime;

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Any mtime write restarts the prescaler so the next increment is a full period away.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     presc <= '0;
    else if (wr_lo | wr_hi | tick) presc <= '0;
    else                           presc <= presc + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      mtime         <= '0;
    else if (wr_lo) mtime[31:0]   <= bus.i_wrdata;
    else if (wr_hi) mtime[63:32]  <= bus.i_wrdata;
    else if (tick)  mtime         <= mtime + 64'd1;
  end

  logic [N_HARTS-1:0]       wr_msip, wr_cmp_lo, wr_cmp_hi;
  logic [N_HARTS-1:0][63:0] mtimecmp;

  for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
    assign wr_msip[h]   = wr & hit_msip & (msip_h == 3'(h));
    assign wr_cmp_lo[h] = wr & hit_cmp & (cmp_h == 3'(h)) & ~cmp_hi;
    assign wr_cmp_hi[h] = wr & hit_cmp & (cmp_h == 3'(h)) &  cmp_hi;

    clint_multi_hart u_hart (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .wr_msip   (wr_msip[h]),
      .wr_cmp_lo (wr_cmp_lo[h]),
      .wr_cmp_hi (wr_cmp_hi[h]),
      .wrdata    (bus.i_wrdata),
      .mtime     (mtime),
      .msip      (o_msip[h]),
      .mtimecmp  (mtimecmp[h]),
      .mtip      (o_mtip[h])
    );
  end

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (hit_lo)      rd_val = mtime[31:0];
    else if (hit_hi) rd_val = mtime[63:32];
    for (int h = 0; h < N_HARTS; h++) begin
      if (hit_msip && msip_h == 3'(h)) rd_val = {31'd0, o_msip[h]};
      if (hit_cmp && cmp_h == 3'(h))   rd_val = cmp_hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
    end
  end

  logic        ack_q, err_q;
  logic [31:0] rdata_q;

  // Read data is the pre-write value on a combined read/write since rd_val is pre-edge state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= acc;
      err_q   <= acc & ~valid;
      rdata_q <= (bus.i_ren & valid) ? rd_val : 32'd0;
    end
  end

  assign bus.o_ack    = ack_q;
  assign bus.o_err    = err_q;
  assign bus.o_rddata = rdata_q;
endmodule

// File: tb/tb_clint_multi.sv
// Bench for clint_multi: table vectors, directed timer/prescaler/reset sequences and
// random traffic, all checked against a behavioural register-map model.
module tb_clint_multi;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int          NH   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [NH-1:0] msip1, mtip1, msip4, mtip4;

  clint_multi_if b1();
  clint_multi_if b4();
  assign b1.i_wen = wen;  assign b1.i_ren = ren;  assign b1.i_addr = addr;  assign b1.i_wrdata = wdata;
  assign b4.i_wen = wen;  assign b4.i_ren = ren;  assign b4.i_addr = addr;  assign b4.i_wrdata = wdata;

  clint_multi #(.BASE_ADDR(BASE), .N_HARTS(NH), .TICK_DIV(1)) dut (
    .i_clk(clk), .i_rst(rst), .bus(b1), .o_msip(msip1), .o_mtip(mtip1));
  clint_multi #(.BASE_ADDR(BASE), .N_HARTS(NH), .TICK_DIV(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .bus(b4), .o_msip(msip4), .o_mtip(mtip4));

  int n_vec = 0;
  int n_bad = 0;

  // Reference state for the TICK_DIV=1 instance.
  logic [63:0]   m_mtime;
  logic [63:0]   m_cmp [NH];
  logic [NH-1:0] m_msip;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mtime = '0;
    m_msip  = '0;
    for (int h = 0; h < NH; h++) m_cmp[h] = '1;
  endfunction

  // Kind: 0 unmapped, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi.
  function automatic int decode(input logic [31:0] a, output int h);
    logic [31:0] o;
    o = a - BASE;
    h = 0;
    if (a[1:0] != 2'b00) return 0;
    if (o < 32'(4 * NH)) begin h = int'(o >> 2); return 1; end
    if (o >= 32'h4000 && o < 32'h4000 + 32'(8 * NH)) begin
      h = int'((o - 32'h4000) >> 3);
      return o[2] ? 3 : 2;
    end
    if (o == 32'hBFF8) return 4;
    if (o == 32'hBFFC) return 5;
    return 0;
  endfunction

  // One bus cycle: drive, predict, clock, compare the TICK_DIV=1 instance.
  task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    int k, h;
    logic [31:0]   rv;
    logic [NH-1:0] e_mtip;
    wen = w; ren = r; addr = a; wdata = d;
    k = decode(a, h);
    case (k)
      1:       rv = {31'd0, m_msip[h]};
      2:       rv = m_cmp[h][31:0];
      3:       rv = m_cmp[h][63:32];
      4:       rv = m_mtime[31:0];
      5:       rv = m_mtime[63:32];
      default: rv = '0;
    endcase
    for (int i = 0; i < NH; i++) e_mtip[i] = (m_mtime >= m_cmp[i]);
    if (w && k == 4)      m_mtime[31:0]  = d;
    else if (w && k == 5) m_mtime[63:32] = d;
    else                  m_mtime        = m_mtime + 64'd1;
    if (w && k == 1) m_msip[h]        = d[0];
    if (w && k == 2) m_cmp[h][31:0]   = d;
    if (w && k == 3) m_cmp[h][63:32]  = d;
    @(posedge clk); #1;
    chk("ack",    64'(b1.o_ack),    64'(w | r));
    chk("err",    64'(b1.o_err),    64'((w | r) && k == 0));
    chk("rddata", 64'(b1.o_rddata), (r && k != 0) ? 64'(rv) : 64'd0);
    chk("msip",   64'(msip1),       64'(m_msip));
    chk("mtip",   64'(mtip1),       64'(e_mtip));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    wen = 0; ren = 0; addr = '0; wdata = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic        w, r;
    logic [31:0] off, d;
    logic        e_err;
    logic [31:0] e_rd;
  } vec_t;
  vec_t tbl [17];

  logic [31:0] pool [14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0000, 32'h0000_0001, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h0000, 32'h0,         1'b0, 32'h1};
    tbl[2]  = '{1'b1, 1'b0, 32'h0004, 32'hFFFF_FFFE, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0004, 32'h0,         1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0002, 32'h0,         1'b1, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h4010, 32'h0,         1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h8000, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b1, 32'h4000, 32'h0,         1'b0, 32'hFFFF_FFFF};
    tbl[8]  = '{1'b1, 1'b0, 32'h4004, 32'h1234_5678, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 32'h4004, 32'h0,         1'b0, 32'h1234_5678};
    tbl[10] = '{1'b0, 1'b1, 32'h4000, 32'h0,         1'b0, 32'hFFFF_FFFF};
    tbl[11] = '{1'b0, 1'b1, 32'h0008, 32'h0,         1'b1, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 32'hC000, 32'h0,         1'b1, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 32'hBFF9, 32'h0000_0077, 1'b1, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 32'h4012, 32'h0000_0055, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 1'b1, 32'h0000, 32'h0,         1'b0, 32'h1};
    tbl[16] = '{1'b0, 1'b1, 32'h8000, 32'h0,         1'b1, 32'h0};

    pool = '{32'h0, 32'h4, 32'h8, 32'h2, 32'h4000, 32'h4004, 32'h4008, 32'h400C,
             32'h4010, 32'hBFF8, 32'hBFFC, 32'h8000, 32'hC000, 32'hFFFF_FFFC};

    // Reset state
    #1 rst = 1'b1;
    model_reset();
    #11;
    chk("rst_ack",   64'(b1.o_ack),    64'd0);
    chk("rst_err",   64'(b1.o_err),    64'd0);
    chk("rst_rd",    64'(b1.o_rddata), 64'd0);
    chk("rst_msip",  64'(msip1),       64'd0);
    chk("rst_mtip",  64'(mtip1),       64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset release: 10 idle cycles, then read mtime low
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("rel_mtip", 64'(mtip1), 64'd0);
    end
    cyc(1'b0, 1'b1, BASE + 32'hBFF8, 32'd0);
    n_vec++;
    if (b1.o_rddata < 32'd10 || b1.o_rddata > 32'd12) begin
      n_bad++;
      $display("FAIL rel_mtime: got %0d expected 10..12", b1.o_rddata);
    end
    chk("rel_ack",  64'(b1.o_ack),    64'd1);
    chk("rel_err",  64'(b1.o_err),    64'd0);
    chk("rel_div4", 64'(b4.o_rddata), 64'd2);

    // Prescaler restart: mtime low=5, then read every cycle on the TICK_DIV=4 instance
    cyc(1'b1, 1'b0, BASE + 32'hBFF8, 32'd5);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b1, BASE + 32'hBFF8, 32'd0);
      chk("div4_seq", 64'(b4.o_rddata), 64'(5 + (k - 1) / 4));
    end

    // Table vectors from a fresh reset
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].w, tbl[i].r, BASE + tbl[i].off, tbl[i].d);
      chk("tbl_ack", 64'(b1.o_ack),    64'd1);
      chk("tbl_err", 64'(b1.o_err),    64'(tbl[i].e_err));
      chk("tbl_rd",  64'(b1.o_rddata), 64'(tbl[i].e_rd));
    end

    // Timer interrupt on hart 1
    cyc(1'b1, 1'b0, BASE + 32'h400C, 32'd0);
    cyc(1'b1, 1'b0, BASE + 32'h4008, 32'd100);
    begin
      int guard = 0;
      while (m_mtime != 64'd100 && guard < 200) begin idle(); guard++; end
      if (guard >= 200) begin
        n_vec++; n_bad++;
        $display("FAIL tmr_timeout: mtime never reached 100");
      end
    end
    chk("tmr_pre",  64'(mtip1[1]), 64'd0);
    idle();
    chk("tmr_on1",  64'(mtip1[1]), 64'd1);
    chk("tmr_on0",  64'(mtip1[0]), 64'd0);
    cyc(1'b1, 1'b0, BASE + 32'h4008, 32'hFFFF_FFFF);
    chk("tmr_hold", 64'(mtip1[1]), 64'd1);
    idle();
    chk("tmr_off",  64'(mtip1[1]), 64'd0);

    // Carry and wrap
    cyc(1'b1, 1'b0, BASE + 32'hBFF8, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b0, BASE + 32'hBFFC, 32'd0);
    idle(); idle();
    cyc(1'b0, 1'b1, BASE + 32'hBFFC, 32'd0);
    chk("carry_hi", 64'(b1.o_rddata), 64'd1);
    cyc(1'b1, 1'b0, BASE + 32'hBFFC, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b0, BASE + 32'hBFF8, 32'hFFFF_FFFF);
    idle();
    cyc(1'b0, 1'b1, BASE + 32'hBFF8, 32'd0);
    chk("wrap_lo",   64'(b1.o_rddata), 64'd0);
    chk("wrap_mtip", 64'(mtip1),       64'd0);
    cyc(1'b0, 1'b1, BASE + 32'hBFFC, 32'd0);
    chk("wrap_hi",   64'(b1.o_rddata), 64'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic w, r;
      logic [31:0] d;
      w = ($urandom % 3) == 0;
      r = ($urandom % 2) == 0;
      d = ($urandom % 2) ? 32'($urandom_range(0, 60)) : $urandom;
      cyc(w, r, BASE + pool[$urandom % 14], d);
    end

    // Software interrupt with simultaneous read
    cyc(1'b1, 1'b0, BASE, 32'd0);
    cyc(1'b1, 1'b1, BASE, 32'd1);
    chk("sim_rd",   64'(b1.o_rddata), 64'd0);
    chk("sim_msip", 64'(msip1[0]),    64'd1);
    chk("sim_ack",  64'(b1.o_ack),    64'd1);

    // Reset mid-access: outputs clear at once and the access is never acked
    wen = 1'b0; ren = 1'b1; addr = BASE + 32'hBFF8;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("mid_ack",  64'(b1.o_ack),    64'd0);
    chk("mid_err",  64'(b1.o_err),    64'd0);
    chk("mid_rd",   64'(b1.o_rddata), 64'd0);
    chk("mid_msip", 64'(msip1),       64'd0);
    chk("mid_mtip", 64'(mtip1),       64'd0);
    @(posedge clk); #1;
    chk("mid_noack", 64'(b1.o_ack),   64'd0);
    ren = 1'b0;
    #1 rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/clint_multi.md
CLINT_MULTI -- requirements
Module: clint_multi

Interface
REQ-001 Parameter BASE_ADDR, default 32'h2000_0000: base of the 0xC000-byte register window.
REQ-002 Parameter N_HARTS, default 2: number of harts served, legal range 1..8.
REQ-003 Parameter TICK_DIV, default 1: i_clk cycles per mtime increment, legal range 1..65535.
REQ-004 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  in  1  reset; asynchronous and active-high.
REQ-006 i_wen  in  1  write request this cycle.
REQ-007 i_ren  in  1  read request this cycle.
REQ-008 i_addr  in  32  byte address of the access.
REQ-009 i_wrdata  in  32  write data.
REQ-010 o_rddata  out  32  registered read data; valid while o_ack=1.
REQ-011 o_ack  out  1  single-cycle acknowledge, one cycle after each accepted access.
REQ-012 o_err  out  1  qualifies o_ack: the access was unmapped or misaligned.
REQ-013 o_msip  out  N_HARTS  per-hart software interrupt.
REQ-014 o_mtip  out  N_HARTS  per-hart timer interrupt, registered.

Function
REQ-015 Address map, offsets from BASE_ADDR:
- msip[h] at 4*h; only bit 0 is implemented, and bits 31:1 read 0.
- mtimecmp[h] low word at 0x4000+8*h, high word at 0x4004+8*h.
- mtime low word at 0xBFF8, high word at 0xBFFC.
REQ-016 An access is accepted in any cycle with i_wen|i_ren=1; there is no backpressure.
REQ-017 Each accepted access produces o_ack=1 on the next cycle only; back-to-back accesses produce back-to-back acks.
REQ-018 If i_addr[1:0]!=0, or i_addr is outside the map, or h>=N_HARTS: no state changes, o_err=1 with the ack, and o_rddata=0.
REQ-019 Read: o_rddata takes the addressed register value as sampled at the accept edge; when no read is acked, o_rddata=0.
REQ-020 If i_wen and i_ren are both high, the write is performed, the read returns the pre-write value, and exactly one ack is issued.
REQ-021 Prescaler: a counter runs 0..TICK_DIV-1 and wraps; tick=1 in the cycle the counter equals TICK_DIV-1. With TICK_DIV=1, tick=1 every cycle.
REQ-022 On tick, mtime increments by 1 as a full 64-bit value, carrying from low to high; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
REQ-023 Write to an mtime word: that word takes i_wrdata and the other word holds; there is no increment that cycle; the prescaler restarts at 0.
REQ-024 Write to a mtimecmp word changes only that word; the other word is unchanged.
REQ-025 Write to msip[h]: o_msip[h] takes i_wrdata[0] on the next edge.
REQ-026 o_mtip[h] is registered: it equals (mtime >= mtimecmp[h]), unsigned 64-bit compare, as evaluated in the previous cycle.
- o_mtip[h] asserts one cycle after mtime reaches mtimecmp[h].
- o_mtip[h] deasserts one cycle after a write makes mtimecmp[h] > mtime.
REQ-027 o_mtip[h] is level-sensitive and has no latch; it stays 1 until software raises mtimecmp[h] or writes mtime below it.
REQ-028 mtime wrap-around: o_mtip[h] follows the compare, so it drops when mtime wraps to 0 unless mtimecmp[h]=0.
REQ-029 All harts share one mtime; mtimecmp[h] and msip[h] are fully independent per hart.

Reset
REQ-030 Asserting i_rst, at any time including mid-access, immediately sets:
- mtime=0, prescaler=0, and every mtimecmp[h]=64'hFFFF_FFFF_FFFF_FFFF;
- o_msip=0, o_mtip=0, o_ack=0, o_err=0, o_rddata=0.
REQ-031 An access in flight at reset is dropped and is not acked.
REQ-032 After i_rst deasserts, the first mtime increment occurs on the TICK_DIV-th rising edge.

Verification
REQ-033 The bench SHALL cover the following directed scenarios (TICK_DIV=1, N_HARTS=2 unless stated):
- Reset release: read mtime low after 10 idle cycles -> rddata in 10..12, o_ack=1, o_err=0; o_mtip=2'b00 throughout.
- Timer interrupt: write mtimecmp[1] high=0 then low=100; wait until mtime=100 -> o_mtip[1]=1 one cycle later, o_mtip[0]=0; write mtimecmp[1] low=0xFFFF_FFFF -> o_mtip[1]=0 one cycle after.
- Carry and wrap: write mtime low=0xFFFF_FFFE and high=0; after 2 ticks read high -> 1. Write high=0xFFFF_FFFF and low=0xFFFF_FFFF; after 1 tick read both words -> 0, 0.
- Prescaler, TICK_DIV=4: mtime advances 1 per 4 cycles; a write to mtime low=5 restarts the count -> reads 6 exactly 4 cycles after the write.
- Errors: read BASE+0x0002, read BASE+0x4010 (hart 2), write BASE+0x8000 -> each gives o_ack=1, o_err=1, rddata=0, no state change.
- Software interrupt and simultaneous access: write msip[0]=1 with i_ren=1 at the same address -> read returns 0, o_msip[0]=1 next cycle. Then assert i_rst mid-access -> no ack, and all outputs are 0 immediately.
